filter_reduce_accum_unit: RTL and testbench

//  Next-generation filter/reduce stage of the trace pipeline. Bins each N-wide input vector against
//  M per-chain bin edges and reduces the N x M hit matrix along a chosen axis. New vs. prior FRU:
//  a per-chain frame accumulation mode (bof..eof), saturating accumulators, and runtime firmware

---
 rtl/filter_reduce_accum_unit.sv | 202 ++++++++++++++++++++
 tb/tb_filter_reduce_accum_unit.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/filter_reduce_accum_unit.sv
// Filter/reduce stage: bins N-lane vectors against per-chain edge sets,
// reduces the hit matrix and optionally accumulates per-chain frames.
module filter_reduce_accum_unit #(
  parameter int N = 8,
  parameter int M = 8,
  parameter int DATA_WIDTH = 32,
  parameter int ACC_WIDTH = 16,
  parameter int MAX_CHAINS = 4,
  parameter int PERSONAL_CONFIG_ID = 0,
  parameter int FUVRF_SIZE = 4,
  parameter logic [FUVRF_SIZE-1:0][M-1:0][DATA_WIDTH-1:0] INIT_EDGES = '0
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               tracing,
  input  logic                               valid_in,
  input  logic                               eof_in,
  input  logic                               bof_in,
  input  logic [$clog2(MAX_CHAINS)-1:0]      chainId_in,
  input  logic [7:0]                         configId,
  input  logic [7:0]                         configData,
  input  logic [N-1:0][DATA_WIDTH-1:0]       vector_in,
  output logic [N-1:0][DATA_WIDTH-1:0]       vector_out,
  output logic [$clog2(MAX_CHAINS)-1:0]      chainId_out,
  output logic                               valid_out,
  output logic                               eof_out,
  output logic                               bof_out
);

  localparam int CW = $clog2(MAX_CHAINS);
  localparam int AW = (FUVRF_SIZE > 1) ? $clog2(FUVRF_SIZE) : 1;
  localparam int CNTW = $clog2(N + 1);
  localparam int SW = ((ACC_WIDTH > CNTW) ? ACC_WIDTH : CNTW) + 1;
  localparam logic [SW-1:0] ACC_MAX =
    {{(SW-ACC_WIDTH){1'b0}}, {ACC_WIDTH{1'b1}}};

  typedef enum logic [1:0] {
    OP_PASS = 2'd0,
    OP_RED  = 2'd1,
    OP_ACC  = 2'd2,
    OP_RSV  = 2'd3
  } op_e;

  typedef logic [M-1:0][DATA_WIDTH-1:0] edge_t;

  op_e                          fw_op   [MAX_CHAINS];
  logic [AW-1:0]                fw_addr [MAX_CHAINS];
  logic [1:0]                   fw_axis [MAX_CHAINS];
  edge_t                        edges   [FUVRF_SIZE];
  logic [N-1:0][ACC_WIDTH-1:0]  acc     [MAX_CHAINS];

  logic [7:0] cfg_b0;
  logic [7:0] cfg_b1;
  logic [1:0] cfg_cnt;

  logic                         s1_valid;
  logic                         s1_bof;
  logic                         s1_eof;
  logic [CW-1:0]                s1_chain;
  logic [N-1:0][DATA_WIDTH-1:0] s1_vec;
  op_e                          s1_op;
  logic [1:0]                   s1_axis;
  edge_t                        s1_edges;

  logic [M-1:0][N-1:0]          hit;
  logic [N-1:0][CNTW-1:0]       r;
  logic [N-1:0][SW-1:0]         sum;
  logic [N-1:0][ACC_WIDTH-1:0]  acc_nxt;
  logic [N-1:0][DATA_WIDTH-1:0] res;
  logic                         s2_fire;
  logic                         emit;

  // Bytes arrive as chain, field, value; a dropped configId aborts a packet.
  always_ff @(posedge clk) begin
    if (reset) begin
      cfg_b0  <= '0;
      cfg_b1  <= '0;
      cfg_cnt <= '0;
      for (int c = 0; c < MAX_CHAINS; c++) begin
        fw_op[c]   <= OP_PASS;
        fw_addr[c] <= '0;
        fw_axis[c] <= '0;
      end
      for (int k = 0; k < FUVRF_SIZE; k++)
        edges[k] <= INIT_EDGES[k];
    end else if (configId == 8'(PERSONAL_CONFIG_ID)) begin
      cfg_b0 <= cfg_b1;
      cfg_b1 <= configData;
      if (cfg_cnt == 2'd2) begin
        cfg_cnt <= '0;
        if (cfg_b0 < 8'(MAX_CHAINS)) begin
          case (cfg_b1)
            8'd0:    fw_op[cfg_b0[CW-1:0]]   <= op_e'(configData[1:0]);
            8'd1:    fw_addr[cfg_b0[CW-1:0]] <= configData[AW-1:0];
            8'd2:    fw_axis[cfg_b0[CW-1:0]] <= configData[1:0];
            default: ;
          endcase
        end
      end else begin
        cfg_cnt <= cfg_cnt + 2'd1;
      end
    end else begin
      cfg_cnt <= '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_bof   <= 1'b0;
      s1_eof   <= 1'b0;
      s1_chain <= '0;
      s1_vec   <= '0;
      s1_op    <= OP_PASS;
      s1_axis  <= '0;
      s1_edges <= '0;
    end else begin
      s1_valid <= valid_in && tracing;
      if (valid_in) begin
        s1_bof   <= bof_in;
        s1_eof   <= eof_in;
        s1_chain <= chainId_in;
        s1_vec   <= vector_in;
        s1_op    <= fw_op[chainId_in];
        s1_axis  <= fw_axis[chainId_in];
        s1_edges <= edges[fw_addr[chainId_in]];
      end
    end
  end

  always_comb begin
    hit = '0;
    for (int j = 0; j < M - 1; j++)
      for (int i = 0; i < N; i++)
        hit[j][i] = (s1_vec[i] > s1_edges[j]) &&
                    (s1_vec[i] <= s1_edges[j+1]);
    for (int i = 0; i < N; i++)
      hit[M-1][i] = s1_vec[i] > s1_edges[M-1];
  end

  // Axis 2 counts each bin across lanes; otherwise each lane across bins.
  always_comb begin
    r = '0;
    if (s1_axis == 2'd2) begin
      for (int b = 0; b < M; b++)
        for (int l = 0; l < N; l++)
          r[b] = r[b] + CNTW'(hit[b][l]);
    end else begin
      for (int l = 0; l < N; l++)
        for (int b = 0; b < M; b++)
          r[l] = r[l] + CNTW'(hit[b][l]);
    end
  end

  always_comb begin
    sum     = '0;
    acc_nxt = '0;
    for (int l = 0; l < N; l++) begin
      sum[l] = (s1_bof ? '0 : SW'(acc[s1_chain][l])) + SW'(r[l]);
      acc_nxt[l] = (sum[l] > ACC_MAX) ? ACC_MAX[ACC_WIDTH-1:0]
                                      : sum[l][ACC_WIDTH-1:0];
    end
  end

  always_comb begin
    res = s1_vec;
    unique case (1'b1)
      s1_op == OP_RED:
        for (int l = 0; l < N; l++) res[l] = DATA_WIDTH'(r[l]);
      s1_op == OP_ACC:
        for (int l = 0; l < N; l++) res[l] = DATA_WIDTH'(acc_nxt[l]);
      default: res = s1_vec;
    endcase
  end

  assign s2_fire = s1_valid && tracing;
  assign emit    = s2_fire && ((s1_op != OP_ACC) || s1_eof);

  // acc is written at the end of stage 2, so a same-chain successor reads it fresh.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_out   <= 1'b0;
      bof_out     <= 1'b0;
      eof_out     <= 1'b0;
      chainId_out <= '0;
      vector_out  <= '0;
      for (int c = 0; c < MAX_CHAINS; c++)
        acc[c] <= '0;
    end else begin
      valid_out <= emit;
      if (s2_fire && s1_op == OP_ACC)
        acc[s1_chain] <= acc_nxt;
      if (emit) begin
        bof_out     <= s1_bof;
        eof_out     <= s1_eof;
        chainId_out <= s1_chain;
        vector_out  <= res;
      end
    end
  end

endmodule

// File: tb/tb_filter_reduce_accum_unit.sv
// Bench: two instances (ACC_WIDTH 16 and 4) share stimulus; a per-instance
// expectation queue is checked on the falling edge with exact cycle timing.
module tb_filter_reduce_accum_unit;

  typedef logic [7:0][31:0] vec_t;

  typedef struct {
    vec_t        v;
    logic [1:0]  ch;
    logic        b;
    logic        e;
    int unsigned cyc;
  } exp_t;

  typedef struct {
    logic [1:0] ch;
    vec_t       vin;
    vec_t       exp;
  } tv_t;

  localparam logic [3:0][7:0][31:0] EDGES = {
    512'd0,
    32'd7,  32'd6,  32'd5,  32'd4,  32'd3,  32'd2,  32'd1,  32'd0,
    32'd70, 32'd60, 32'd50, 32'd40, 32'd30, 32'd20, 32'd10, 32'd0
  };

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       tracing = 1'b1;
  logic       valid_in = 1'b0;
  logic       eof_in = 1'b0;
  logic       bof_in = 1'b0;
  logic [1:0] chainId_in = '0;
  logic [7:0] configId = 8'hFF;
  logic [7:0] configData = '0;
  vec_t       vector_in = '0;

  vec_t       vo_a, vo_b;
  logic [1:0] ch_a, ch_b;
  logic       v_a, v_b, e_a, e_b, b_a, b_b;

  int unsigned cyc = 0;
  int checks = 0;
  int errors = 0;
  exp_t q[2][$];
  tv_t tbl[6];

  filter_reduce_accum_unit #(
    .ACC_WIDTH(16), .INIT_EDGES(EDGES)
  ) dut (
    .clk(clk), .reset(reset), .tracing(tracing),
    .valid_in(valid_in), .eof_in(eof_in), .bof_in(bof_in),
    .chainId_in(chainId_in), .configId(configId),
    .configData(configData), .vector_in(vector_in),
    .vector_out(vo_a), .chainId_out(ch_a), .valid_out(v_a),
    .eof_out(e_a), .bof_out(b_a)
  );

  filter_reduce_accum_unit #(
    .ACC_WIDTH(4), .INIT_EDGES(EDGES)
  ) dut4 (
    .clk(clk), .reset(reset), .tracing(tracing),
    .valid_in(valid_in), .eof_in(eof_in), .bof_in(bof_in),
    .chainId_in(chainId_in), .configId(configId),
    .configData(configData), .vector_in(vector_in),
    .vector_out(vo_b), .chainId_out(ch_b), .valid_out(v_b),
    .eof_out(e_b), .bof_out(b_b)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  initial begin
    #500000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  function automatic vec_t mk(input int unsigned a0, a1, a2, a3,
                              input int unsigned a4, a5, a6, a7);
    vec_t v;
    v[0] = a0; v[1] = a1; v[2] = a2; v[3] = a3;
    v[4] = a4; v[5] = a5; v[6] = a6; v[7] = a7;
    return v;
  endfunction

  function automatic vec_t splat(input int unsigned x);
    return mk(x, x, x, x, x, x, x, x);
  endfunction

  task automatic mon(input int w, input logic v, input vec_t o,
                     input logic [1:0] c, input logic b, input logic e);
    exp_t x;
    while (q[w].size() > 0 && q[w][0].cyc < cyc) begin
      x = q[w].pop_front();
      checks++;
      errors++;
      $display("FAIL missing_out%0d due=%0d want vec=%h", w, x.cyc, x.v);
    end
    if (v === 1'b1) begin
      checks++;
      if (q[w].size() == 0 || q[w][0].cyc != cyc) begin
        errors++;
        $display("FAIL unexpected_out%0d cyc=%0d got vec=%h", w, cyc, o);
      end else begin
        x = q[w].pop_front();
        if (o !== x.v || c !== x.ch || b !== x.b || e !== x.e) begin
          errors++;
          $display("FAIL out%0d cyc=%0d got vec=%h ch=%0d b=%0d e=%0d want vec=%h ch=%0d b=%0d e=%0d",
                   w, cyc, o, c, b, e, x.v, x.ch, x.b, x.e);
        end
      end
    end
  endtask

  always @(negedge clk) begin
    mon(0, v_a, vo_a, ch_a, b_a, e_a);
    mon(1, v_b, vo_b, ch_b, b_b, e_b);
  end

  task automatic chk_reset(input string nm);
    checks++;
    if (v_a !== 1'b0 || vo_a !== '0 || ch_a !== '0 || b_a !== 1'b0 ||
        e_a !== 1'b0 || v_b !== 1'b0 || vo_b !== '0 || ch_b !== '0 ||
        b_b !== 1'b0 || e_b !== 1'b0) begin
      errors++;
      $display("FAIL %s got v=%b/%b vec=%h ch=%0d want all zero",
               nm, v_a, v_b, vo_a, ch_a);
    end
  endtask

  task automatic expect_out(input vec_t ea, input vec_t eb,
                            input logic [1:0] c, input logic b,
                            input logic e);
    exp_t x;
    x.ch = c; x.b = b; x.e = e; x.cyc = cyc + 2;
    x.v = ea;
    q[0].push_back(x);
    x.v = eb;
    q[1].push_back(x);
  endtask

  task automatic send(input logic [1:0] c, input vec_t v,
                      input logic b, input logic e);
    valid_in = 1'b1; chainId_in = c; vector_in = v;
    bof_in = b; eof_in = e;
    @(posedge clk); #1;
    valid_in = 1'b0; bof_in = 1'b0; eof_in = 1'b0;
  endtask

  task automatic cfg(input logic [7:0] c, input logic [7:0] f,
                     input logic [7:0] val);
    configId = 8'd0;
    configData = c;   @(posedge clk); #1;
    configData = f;   @(posedge clk); #1;
    configData = val; @(posedge clk); #1;
    configId = 8'hFF;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    tbl[0] = '{2'd0, mk(0,1,2,3,4,5,6,7), mk(0,1,2,3,4,5,6,7)};
    tbl[1] = '{2'd0, mk(32'hDEADBEEF,1,32'hFFFFFFFF,9,0,3,5,8),
                     mk(32'hDEADBEEF,1,32'hFFFFFFFF,9,0,3,5,8)};
    tbl[2] = '{2'd1, splat(15), mk(0,8,0,0,0,0,0,0)};
    tbl[3] = '{2'd1, mk(0,5,10,15,20,25,30,35), mk(2,2,2,1,0,0,0,0)};
    tbl[4] = '{2'd1, mk(0,70,71,100,32'hFFFFFFFF,60,61,10),
                     mk(1,0,0,0,0,1,2,3)};
    tbl[5] = '{2'd3, mk(0,1,7,8,3,0,100,2), mk(0,1,1,1,1,0,1,1)};

    idle(3);
    reset = 1'b0;
    @(negedge clk);
    chk_reset("reset_state");
    #1;

    // Pass-through first, before any firmware is written.
    expect_out(tbl[0].exp, tbl[0].exp, tbl[0].ch, 1'b0, 1'b0);
    send(tbl[0].ch, tbl[0].vin, 1'b0, 1'b0);
    idle(4);

    cfg(1, 0, 1); cfg(1, 2, 2);
    cfg(3, 0, 1); cfg(3, 1, 1);
    cfg(2, 0, 2); cfg(2, 2, 2);

    for (int i = 0; i < 6; i++) begin
      expect_out(tbl[i].exp, tbl[i].exp, tbl[i].ch, 1'b0, 1'b0);
      send(tbl[i].ch, tbl[i].vin, 1'b0, 1'b0);
    end
    idle(4);

    // Partial config packet must be discarded.
    configId = 8'd0; configData = 8'd1; idle(1);
    configData = 8'd0; idle(1);
    configId = 8'hFF; idle(1);
    cfg(3, 2, 0);
    expect_out(mk(0,8,0,0,0,0,0,0), mk(0,8,0,0,0,0,0,0), 2'd1, 1'b0, 1'b0);
    send(1, splat(15), 1'b0, 1'b0);
    idle(4);

    // Frame back-to-back on chain 2; only eof produces output.
    send(2, splat(5), 1'b1, 1'b0);
    send(2, splat(5), 1'b0, 1'b0);
    expect_out(mk(16,0,0,0,0,0,0,8), mk(15,0,0,0,0,0,0,8), 2'd2, 1'b0, 1'b1);
    send(2, splat(75), 1'b0, 1'b1);
    idle(4);

    // Saturation in the narrow instance.
    send(2, splat(5), 1'b1, 1'b0);
    send(2, splat(5), 1'b0, 1'b0);
    expect_out(mk(24,0,0,0,0,0,0,0), mk(15,0,0,0,0,0,0,0), 2'd2, 1'b0, 1'b1);
    send(2, splat(5), 1'b0, 1'b1);
    expect_out(mk(0,8,0,0,0,0,0,0), mk(0,8,0,0,0,0,0,0), 2'd2, 1'b1, 1'b1);
    send(2, splat(15), 1'b1, 1'b1);
    idle(4);

    // Tracing low over the mid vector; config is still taken meanwhile.
    send(2, splat(5), 1'b1, 1'b0);
    idle(2);
    tracing = 1'b0;
    send(2, splat(15), 1'b0, 1'b0);
    cfg(0, 0, 1);
    idle(1);
    checks++;
    if (ch_a !== 2'd2 || e_a !== 1'b1 || b_a !== 1'b1) begin
      errors++;
      $display("FAIL hold_flags got ch=%0d b=%0d e=%0d want ch=2 b=1 e=1",
               ch_a, b_a, e_a);
    end
    tracing = 1'b1;
    idle(1);
    expect_out(mk(8,0,0,0,0,0,0,8), mk(8,0,0,0,0,0,0,8), 2'd2, 1'b0, 1'b1);
    send(2, splat(75), 1'b0, 1'b1);
    expect_out(mk(0,1,1,1,1,1,1,1), mk(0,1,1,1,1,1,1,1), 2'd0, 1'b0, 1'b0);
    send(0, mk(0,5,10,11,70,71,200,1), 1'b0, 1'b0);
    idle(4);

    // Reset mid-frame with a vector still in flight.
    send(2, splat(5), 1'b1, 1'b0);
    idle(1);
    send(2, splat(5), 1'b0, 1'b0);
    reset = 1'b1;
    idle(2);
    reset = 1'b0;
    @(negedge clk);
    chk_reset("reset_midframe");
    #1;
    expect_out(splat(3), splat(3), 2'd0, 1'b0, 1'b0);
    send(0, splat(3), 1'b0, 1'b0);
    cfg(2, 0, 2); cfg(2, 2, 2);
    expect_out(mk(8,0,0,0,0,0,0,0), mk(8,0,0,0,0,0,0,0), 2'd2, 1'b0, 1'b1);
    send(2, splat(5), 1'b0, 1'b1);
    idle(6);

    for (int w = 0; w < 2; w++) begin
      checks++;
      if (q[w].size() != 0) begin
        errors++;
        $display("FAIL drain_out%0d got %0d pending want 0", w, q[w].size());
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
